// File: rtl/f_predict_pc_pkg.sv
// Shared definitions for the fetch-stage next-PC generator and its BTB.
// The execute-stage writer packs BTB entries with the same field layout:
//   {valid, state[1:0], tag[TAG_W-1:0], target[PC_W-1:0]}
package f_predict_pc_pkg;

    localparam int BTB_PC_W      = 13;
    localparam int BTB_IDX_W     = 11;
    localparam int BTB_TAG_W     = BTB_PC_W - BTB_IDX_W;
    localparam int BTB_ENTRY_W   = 1 + 2 + BTB_TAG_W + BTB_PC_W;

    // Field offsets inside one entry
    localparam int BTB_TARGET_LSB = 0;
    localparam int BTB_TAG_LSB    = BTB_PC_W;
    localparam int BTB_STATE_LSB  = BTB_PC_W + BTB_TAG_W;
    localparam int BTB_VALID_BIT  = BTB_STATE_LSB + 2;

    // Two-bit saturating counter encodings
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        FSM_INIT = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_e;

    // Weakly and strongly taken both have the upper counter bit set
    function automatic logic ctr_taken(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/f_btb_ram.sv
// Branch target buffer storage: 2**DEPTH_W x DATA_W, one synchronous write
// port and one asynchronous read port. Not reset so it maps onto RAM; the
// parent clears it with a sweep after reset.
//   clk   in  clock
//   we    in  write enable
//   waddr in  write index
//   wdata in  write data
//   raddr in  read index
//   rdata out read data (combinational)
module f_btb_ram #(
    parameter int DEPTH_W = 11,
    parameter int DATA_W  = 18
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_r [2**DEPTH_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/f_predict_pc.sv
// Fetch-stage next-PC generator with a direct-mapped BTB.
// Holds the fetch PC, looks up the BTB every cycle and presents the predicted
// successor PC in the same cycle. After reset the BTB is cleared by a sweep of
// 2**IDX_W cycles before fetch becomes valid.
//   clk          in  clock
//   rst_n        in  asynchronous active-low reset
//   stall        in  hold PC
//   redirect     in  execute-stage misprediction, overrides prediction
//   redirect_pc  in  correct next PC
//   w_data       in  BTB entry {valid, state[1:0], tag, target}
//   w_addr       in  BTB write index
//   wen          in  BTB write enable
//   pc           out current fetch PC
//   pc_predicted out predicted PC following pc
//   pred_taken   out BTB hit predicting taken
//   f_valid      out pc/pc_predicted meaningful
//   init_busy    out BTB clear sweep in progress
module f_predict_pc
    import f_predict_pc_pkg::*;
#(
    parameter int              PC_W     = BTB_PC_W,
    parameter int              IDX_W    = BTB_IDX_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall,
    input  logic                            redirect,
    input  logic [PC_W-1:0]                 redirect_pc,
    input  logic [1+2+(PC_W-IDX_W)+PC_W-1:0] w_data,
    input  logic [IDX_W-1:0]                w_addr,
    input  logic                            wen,
    output logic [PC_W-1:0]                 pc,
    output logic [PC_W-1:0]                 pc_predicted,
    output logic                            pred_taken,
    output logic                            f_valid,
    output logic                            init_busy
);

    localparam int TAG_W     = PC_W - IDX_W;
    localparam int ENTRY_W   = 1 + 2 + TAG_W + PC_W;
    localparam int TAG_LSB   = PC_W;
    localparam int STATE_LSB = PC_W + TAG_W;
    localparam int VALID_BIT = STATE_LSB + 2;
    localparam logic [IDX_W-1:0] CLR_LAST = {IDX_W{1'b1}};

    fsm_e               fsm_r;
    logic [IDX_W-1:0]   clr_idx_r;
    logic [PC_W-1:0]    pc_r;
    logic               f_valid_r;
    logic               init_busy_r;

    logic               ram_we_s;
    logic [IDX_W-1:0]   ram_waddr_s;
    logic [ENTRY_W-1:0] ram_wdata_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic [ENTRY_W-1:0] entry_s;
    logic               hit_s;
    logic               taken_s;
    logic [PC_W-1:0]    pc_pred_s;

    // BTB write-port mux: the clear sweep owns the port during INIT
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {IDX_W{1'b0}};
        ram_wdata_s = {ENTRY_W{1'b0}};
        if (fsm_r == FSM_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_idx_r;
            ram_wdata_s = {ENTRY_W{1'b0}};
        end else begin
            ram_we_s    = wen;
            ram_waddr_s = w_addr;
            ram_wdata_s = w_data;
        end
    end

    f_btb_ram #(
        .DEPTH_W (IDX_W),
        .DATA_W  (ENTRY_W)
    ) u_btb_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (pc_r[IDX_W-1:0]),
        .rdata (rd_entry_s)
    );

    // Lookup with same-cycle write bypass; prediction is suppressed in INIT
    always_comb begin
        entry_s = rd_entry_s;
        if (wen && (w_addr == pc_r[IDX_W-1:0])) begin
            entry_s = w_data;
        end else begin
            entry_s = rd_entry_s;
        end
        hit_s   = entry_s[VALID_BIT] &&
                  (entry_s[STATE_LSB-1:TAG_LSB] == pc_r[PC_W-1:IDX_W]);
        taken_s = (fsm_r == FSM_RUN) && hit_s &&
                  ctr_taken(entry_s[STATE_LSB+1:STATE_LSB]);
        if (taken_s) begin
            pc_pred_s = entry_s[PC_W-1:0];
        end else begin
            // Wraps modulo 2**PC_W
            pc_pred_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Sweep/run state machine and fetch PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= FSM_INIT;
            clr_idx_r   <= {IDX_W{1'b0}};
            pc_r        <= RESET_PC;
            f_valid_r   <= 1'b0;
            init_busy_r <= 1'b1;
        end else begin
            case (fsm_r)
                FSM_INIT: begin
                    clr_idx_r <= clr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    // stall is ignored while clearing; redirect still lands
                    if (redirect) begin
                        pc_r <= redirect_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (clr_idx_r == CLR_LAST) begin
                        fsm_r       <= FSM_RUN;
                        f_valid_r   <= 1'b1;
                        init_busy_r <= 1'b0;
                    end else begin
                        fsm_r       <= FSM_INIT;
                        f_valid_r   <= 1'b0;
                        init_busy_r <= 1'b1;
                    end
                end
                FSM_RUN: begin
                    if (redirect) begin
                        pc_r <= redirect_pc;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else begin
                        pc_r <= pc_pred_s;
                    end
                end
                default: begin
                    fsm_r       <= FSM_INIT;
                    clr_idx_r   <= {IDX_W{1'b0}};
                    pc_r        <= RESET_PC;
                    f_valid_r   <= 1'b0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign pc           = pc_r;
    assign pc_predicted = pc_pred_s;
    assign pred_taken   = taken_s;
    assign f_valid      = f_valid_r;
    assign init_busy    = init_busy_r;

endmodule

// File: tb/tb_f_predict_pc.sv
// Self-checking bench for f_predict_pc: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the fetch PC and BTB.
module tb_f_predict_pc;

    localparam int NENT = 2048;
    localparam int PCMOD = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [12:0] redirect_pc = 13'd0;
    logic [17:0] w_data = 18'd0;
    logic [10:0] w_addr = 11'd0;
    logic        wen = 1'b0;
    logic [12:0] pc;
    logic [12:0] pc_predicted;
    logic        pred_taken;
    logic        f_valid;
    logic        init_busy;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [17:0] m_btb [NENT];
    int          m_pc;
    int          m_init_left;

    f_predict_pc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .w_data       (w_data),
        .w_addr       (w_addr),
        .wen          (wen),
        .pc           (pc),
        .pc_predicted (pc_predicted),
        .pred_taken   (pred_taken),
        .f_valid      (f_valid),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk_entry(input int v, input int st, input int tg, input int tgt);
        return 18'((v % 2) * 131072 + (st % 4) * 32768 + (tg % 4) * 8192 + (tgt % PCMOD));
    endfunction

    // Called at a falling edge; leaves at the next falling edge
    task automatic step(input logic rd, input logic [12:0] rpc, input logic st,
                        input logic we, input logic [10:0] wa, input logic [17:0] wd);
        logic [17:0] e;
        int          tk;
        int          exp_pred;
        redirect = rd; redirect_pc = rpc; stall = st;
        wen = we; w_addr = wa; w_data = wd;
        #1;
        exp_pred = (m_pc + 1) % PCMOD;
        tk = 0;
        if (m_init_left == 0) begin
            if (we && int'(wa) == m_pc % NENT) e = wd;
            else e = m_btb[m_pc % NENT];
            if (int'(e[17]) == 1 && int'(e[14:13]) == m_pc / NENT && int'(e[16:15]) >= 2)
                tk = 1;
            if (tk == 1) exp_pred = int'(e[12:0]);
        end
        chk_eq("pc", int'(pc), m_pc);
        chk_eq("pc_predicted", int'(pc_predicted), exp_pred);
        chk_eq("pred_taken", int'(pred_taken), tk);
        chk_eq("f_valid", int'(f_valid), (m_init_left == 0) ? 1 : 0);
        chk_eq("init_busy", int'(init_busy), (m_init_left == 0) ? 0 : 1);
        if (m_init_left == 0) begin
            if (we) m_btb[int'(wa)] = wd;
            if (rd) m_pc = int'(rpc);
            else if (!st) m_pc = exp_pred;
        end else begin
            if (rd) m_pc = int'(rpc);
            m_init_left--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 13'd0, 1'b0, 1'b0, 11'd0, 18'd0);
    endtask

    // Biased random cycle: small PC range and tag matches so hits are common
    task automatic rand_step();
        logic        rd;
        logic [12:0] rpc;
        logic        st;
        logic        we;
        logic [10:0] wa;
        logic [17:0] wd;
        int          tg;
        rd = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 9) == 0) rpc = 13'h1FFF;
        else rpc = 13'($urandom_range(0, 63) + NENT * $urandom_range(0, 1));
        st = ($urandom_range(0, 4) == 0);
        we = ($urandom_range(0, 2) == 0);
        wa = 11'((m_pc + $urandom_range(0, 3)) % NENT);
        tg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : m_pc / NENT;
        wd = mk_entry(($urandom_range(0, 5) != 0) ? 1 : 0, $urandom_range(0, 3), tg,
                      $urandom_range(0, 63));
        step(rd, rpc, st, we, wa, wd);
    endtask

    // Called at a falling edge; asserts reset asynchronously, releases at the next falling edge
    task automatic do_reset();
        redirect = 1'b0; stall = 1'b0; wen = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_pc", int'(pc), 0);
        chk_eq("rst_pc_predicted", int'(pc_predicted), 1);
        chk_eq("rst_pred_taken", int'(pred_taken), 0);
        chk_eq("rst_f_valid", int'(f_valid), 0);
        chk_eq("rst_init_busy", int'(init_busy), 1);
        for (int i = 0; i < NENT; i++) m_btb[i] = 18'd0;
        m_pc = 0;
        m_init_left = NENT;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();

        // Sweep length after reset
        n = 0;
        while (init_busy === 1'b1 && n < 4000) begin
            idle();
            n++;
        end
        chk_eq("sweep1_len", n, NENT);
        #1;
        chk_eq("run_pc", int'(pc), 0);
        chk_eq("run_pc_predicted", int'(pc_predicted), 1);
        chk_eq("run_pred_taken", int'(pred_taken), 0);
        chk_eq("run_f_valid", int'(f_valid), 1);

        // Sequential fetch with a two-cycle stall at pc=3
        for (int i = 0; i < 3; i++) begin
            chk_eq("seq_pc", int'(pc), i);
            idle();
        end
        step(1'b0, 13'd0, 1'b1, 1'b0, 11'd0, 18'd0);
        step(1'b0, 13'd0, 1'b1, 1'b0, 11'd0, 18'd0);
        chk_eq("stall_pc", int'(pc), 3);
        idle();
        chk_eq("resume_pc", int'(pc), 4);

        // Taken hit at pc=5
        step(1'b0, 13'd0, 1'b0, 1'b1, 11'h005, mk_entry(1, 2, 0, 13'h100));
        chk_eq("hit_taken", int'(pred_taken), 1);
        chk_eq("hit_target", int'(pc_predicted), 13'h100);
        idle();
        chk_eq("hit_next_pc", int'(pc), 13'h100);
        // Weaken to not-taken and revisit
        step(1'b0, 13'd0, 1'b0, 1'b1, 11'h005, mk_entry(1, 1, 0, 13'h100));
        step(1'b1, 13'h005, 1'b0, 1'b0, 11'd0, 18'd0);
        chk_eq("wnt_pred", int'(pc_predicted), 6);
        chk_eq("wnt_taken", int'(pred_taken), 0);

        // Tag mismatch on the same index
        step(1'b1, 13'h805, 1'b0, 1'b0, 11'd0, 18'd0);
        chk_eq("tag_taken", int'(pred_taken), 0);
        chk_eq("tag_pred", int'(pc_predicted), 13'h806);

        // Same-cycle bypass
        step(1'b1, 13'h010, 1'b0, 1'b0, 11'd0, 18'd0);
        step(1'b0, 13'd0, 1'b0, 1'b1, 11'h010, mk_entry(1, 3, 0, 13'h020));
        chk_eq("bypass_next_pc", int'(pc), 13'h020);

        // Redirect beats stall, then PC wraps
        step(1'b1, 13'h1FFF, 1'b1, 1'b0, 11'd0, 18'd0);
        chk_eq("redir_pc", int'(pc), 13'h1FFF);
        chk_eq("wrap_pred", int'(pc_predicted), 0);
        idle();
        chk_eq("wrap_pc", int'(pc), 0);

        // Randomized run
        for (int i = 0; i < 1500; i++) rand_step();

        // Reset mid-run; random traffic during the sweep must not disturb it
        do_reset();
        n = 0;
        while (init_busy === 1'b1 && n < 4000) begin
            rand_step();
            n++;
        end
        chk_eq("sweep2_len", n, NENT);
        for (int i = 0; i < 1000; i++) rand_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
